ym3438_lfo_seq: RTL and testbench
=================================

# ym3438_lfo_seq

Timing sequencer and register front-end for the LFO datapath. Divides MCLK into the non-overlapping c1/c2 phase enables and runs the 24-slot frame counter that produces fsm_sel23. It stretches chip-level initial clear across one full frame. It also double-buffers the LFO control registers (reg 0x21, reg 0x22 lfo field) so that CPU writes reach the LFO only on a frame boundary.

## Interface
Parameters:
- PHASE_DIV, 6, MCLK cycles per slot; legal range 4..15.
- SLOTS, 24, slots per frame; legal range 2..31.

Ports:
- MCLK  in  1  single clock for all state.
- IC  in  1  synchronous, active-high reset, sampled on the MCLK rising edge.
- reg21_wr  in  1  one-cycle write strobe for reg 0x21.
- reg21_data  in  8  write data for reg 0x21.
- lfo_wr  in  1  one-cycle write strobe for the lfo field of reg 0x22.
- lfo_data  in  4  bit 3 = enable, bits 2:0 = rate.
- c1  out  1  phase-1 enable.
- c2  out  1  phase-2 enable.
- slot  out  5  current slot index, 0..SLOTS-1.
- fsm_sel23  out  1  high for the whole of slot SLOTS-1.
- frame_start  out  1  one-MCLK pulse on the first cycle of slot 0.
- ic_o  out  1  stretched clear to the LFO. It is active-high; the datapath consumes the inverted value.
- reg_21  out  8  committed reg 0x21 value.
- lfo  out  4  committed lfo field value.
- busy  out  1  a write is pending commit.

## Operation
- The phase counter ph runs 0..PHASE_DIV-1 and wraps.
  - c1 = (ph==0 | ph==1).
  - c2 = (ph==PHASE_DIV/2 | ph==PHASE_DIV/2+1), using integer division.
  - c1 and c2 are never high together.
- The slot counter advances when ph==PHASE_DIV-1 and wraps SLOTS-1 -> 0.
- fsm_sel23 = (slot==SLOTS-1).
- frame_start = (slot==0 & ph==0), excluding the first cycle after IC deasserts.
- Shadow registers:
  - Two shadows, sh21 (8 bits) and shlfo (4 bits), each with its own pending flag p21 and plfo.
  - A write strobe loads its shadow and sets its flag. A second write before commit overwrites the shadow, so the last write wins.
  - busy = p21 | plfo.
- Commit point is the MCLK edge where ph==PHASE_DIV-1 and slot==SLOTS-1 (the frame wrap).
  - For each pending flag set, the shadow is copied to its output register and the flag is cleared.
  - Each register commits independently.
- A write strobe in the same cycle as the commit point goes straight to the output register, bypassing the shadow, and clears that flag. Write data wins over the old shadow.
- reg21_wr and lfo_wr in the same cycle: both are accepted.
- IC state machine, three states:
  - CLEAR: IC high. ic_o=1.
  - STRETCH: entered when IC falls. ic_o=1. Leaves when a frame wrap completes, i.e. the counters return to slot 0, ph 0.
  - RUN: ic_o=0.
  - IC high from any state goes to CLEAR.
- While IC=1, write strobes are ignored.

## Timing
- Reset values, with IC high sampled: ph=0, slot=0, c1=1 (from ph==0), c2=0, fsm_sel23=0, frame_start=0, ic_o=1, reg_21=0x00, lfo=0x0, busy=0, state CLEAR.
- While IC stays high, the counters hold at ph=0, slot=0.
- After IC falls, counting starts on the next edge.
  - ic_o stays 1 for exactly SLOTS*PHASE_DIV cycles.
  - ic_o drops on the edge the counters re-enter slot 0, ph 0, and frame_start pulses in that same cycle.
- Write to output latency is 1 to SLOTS*PHASE_DIV cycles. Outputs change only on the commit edge, so they are stable across an entire frame.
- busy rises the cycle after the strobe and falls the cycle after commit.
- IC asserted mid-frame with a write pending: the pending write is discarded and the outputs go to their reset values.

## Test plan
- Reset release, defaults: IC high 10 cycles, then low.
  - ic_o=1 for exactly 144 cycles, then 0.
  - c1 pulses on ph 0,1; c2 pulses on ph 3,4; never overlapping.
  - fsm_sel23 high for 6 cycles every 144.
- Mid-frame write: reg21_wr with 0x02 at slot 5.
  - busy=1 until the slot 23 wrap.
  - reg_21 stays 0x00 until that edge, then reads 0x02.
- Last-write-wins: lfo_wr 0x9 at slot 3, then 0xB at slot 10 → lfo goes to 0xB at the wrap, never 0x9.
- Write at commit edge: lfo_wr 0xC exactly at ph=5, slot=23 → lfo=0xC on the next cycle, busy never rises.
- Reset during pending: reg21_wr 0xFF, then IC high at slot 12 → reg_21 stays 0x00, busy=0, and there is no commit after release.
- Parameter sweep: PHASE_DIV=4, SLOTS=2 → frame is 8 cycles, fsm_sel23 high in cycles 4..7, ic_o stretch is 8 cycles.

Source files
------------

// File: rtl/ym3438_lfo_seq.sv
// LFO timing sequencer: MCLK phase enables, slot/frame counter, stretched clear,
// and frame-aligned double buffering of the LFO control registers.
module ym3438_lfo_seq #(
  parameter int PHASE_DIV = 6,
  parameter int SLOTS     = 24
) (
  input  logic       MCLK,
  input  logic       IC,
  input  logic       reg21_wr,
  input  logic [7:0] reg21_data,
  input  logic       lfo_wr,
  input  logic [3:0] lfo_data,
  output logic       c1,
  output logic       c2,
  output logic [4:0] slot,
  output logic       fsm_sel23,
  output logic       frame_start,
  output logic       ic_o,
  output logic [7:0] reg_21,
  output logic [3:0] lfo,
  output logic       busy
);

  localparam logic [3:0] PH_LAST   = 4'(PHASE_DIV - 1);
  localparam logic [3:0] C2_A      = 4'(PHASE_DIV / 2);
  localparam logic [3:0] C2_B      = 4'(PHASE_DIV / 2 + 1);
  localparam logic [4:0] SLOT_LAST = 5'(SLOTS - 1);

  typedef enum logic [1:0] {ST_CLEAR, ST_STRETCH, ST_RUN} state_t;

  logic [3:0] r_ph;
  logic [4:0] r_slot;
  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_ph_last;
  logic       w_wrap;

  logic [7:0] r_sh21;
  logic [7:0] r_reg21;
  logic       r_p21;
  logic [3:0] r_shlfo;
  logic [3:0] r_lfo;
  logic       r_plfo;

  assign w_ph_last = (r_ph == PH_LAST);
  assign w_wrap    = w_ph_last && (r_slot == SLOT_LAST);

  always_ff @(posedge MCLK) begin
    if (IC) begin
      r_ph   <= 4'd0;
      r_slot <= 5'd0;
    end else if (w_ph_last) begin
      r_ph   <= 4'd0;
      r_slot <= (r_slot == SLOT_LAST) ? 5'd0 : r_slot + 5'd1;
    end else begin
      r_ph <= r_ph + 4'd1;
    end
  end

  assign c1        = (r_ph == 4'd0) || (r_ph == 4'd1);
  assign c2        = (r_ph == C2_A) || (r_ph == C2_B);
  assign slot      = r_slot;
  assign fsm_sel23 = (r_slot == SLOT_LAST);

  always_ff @(posedge MCLK) begin
    if (IC) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR:   w_state_nxt = ST_STRETCH;
      ST_STRETCH: if (w_wrap) w_state_nxt = ST_RUN;
      ST_RUN:     w_state_nxt = ST_RUN;
      default:    w_state_nxt = ST_CLEAR;
    endcase
  end

  // Clear is held until the first full frame after release has elapsed.
  always_comb begin
    ic_o        = 1'b1;
    frame_start = 1'b0;
    if (r_state == ST_RUN) begin
      ic_o        = 1'b0;
      frame_start = (r_slot == 5'd0) && (r_ph == 4'd0);
    end
  end

  // A strobe landing on the wrap edge bypasses the shadow and commits directly.
  always_ff @(posedge MCLK) begin
    if (IC) begin
      r_sh21  <= 8'h00;
      r_reg21 <= 8'h00;
      r_p21   <= 1'b0;
      r_shlfo <= 4'h0;
      r_lfo   <= 4'h0;
      r_plfo  <= 1'b0;
    end else begin
      if (w_wrap) begin
        if (reg21_wr) begin
          r_reg21 <= reg21_data;
          r_p21   <= 1'b0;
        end else if (r_p21) begin
          r_reg21 <= r_sh21;
          r_p21   <= 1'b0;
        end
        if (lfo_wr) begin
          r_lfo  <= lfo_data;
          r_plfo <= 1'b0;
        end else if (r_plfo) begin
          r_lfo  <= r_shlfo;
          r_plfo <= 1'b0;
        end
      end else begin
        if (reg21_wr) begin
          r_sh21 <= reg21_data;
          r_p21  <= 1'b1;
        end
        if (lfo_wr) begin
          r_shlfo <= lfo_data;
          r_plfo  <= 1'b1;
        end
      end
    end
  end

  assign reg_21 = r_reg21;
  assign lfo    = r_lfo;
  assign busy   = r_p21 || r_plfo;

endmodule

// File: tb/tb_ym3438_lfo_seq.sv
// Bench for ym3438_lfo_seq: default (6x24) and minimal (4x2) instances share one
// stimulus stream and are checked every cycle against a frame-position model.
module tb_ym3438_lfo_seq;

  logic       MCLK = 1'b0;
  logic       IC = 1'b1;
  logic       reg21_wr = 1'b0;
  logic [7:0] reg21_data = 8'h00;
  logic       lfo_wr = 1'b0;
  logic [3:0] lfo_data = 4'h0;

  logic       o_c1[2], o_c2[2], o_fsm[2], o_fs[2], o_ic[2], o_busy[2];
  logic [4:0] o_slot[2];
  logic [7:0] o_r21[2];
  logic [3:0] o_lfo[2];

  always #5 MCLK = ~MCLK;

  ym3438_lfo_seq #(.PHASE_DIV(6), .SLOTS(24)) dut0 (
    .MCLK(MCLK), .IC(IC), .reg21_wr(reg21_wr), .reg21_data(reg21_data),
    .lfo_wr(lfo_wr), .lfo_data(lfo_data), .c1(o_c1[0]), .c2(o_c2[0]),
    .slot(o_slot[0]), .fsm_sel23(o_fsm[0]), .frame_start(o_fs[0]), .ic_o(o_ic[0]),
    .reg_21(o_r21[0]), .lfo(o_lfo[0]), .busy(o_busy[0]));

  ym3438_lfo_seq #(.PHASE_DIV(4), .SLOTS(2)) dut1 (
    .MCLK(MCLK), .IC(IC), .reg21_wr(reg21_wr), .reg21_data(reg21_data),
    .lfo_wr(lfo_wr), .lfo_data(lfo_data), .c1(o_c1[1]), .c2(o_c2[1]),
    .slot(o_slot[1]), .fsm_sel23(o_fsm[1]), .frame_start(o_fs[1]), .ic_o(o_ic[1]),
    .reg_21(o_r21[1]), .lfo(o_lfo[1]), .busy(o_busy[1]));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: t = MCLK cycles since IC release; everything else follows from t.
  int m_t[2];
  int m_r21[2], m_s21[2], m_rl[2], m_sl[2];
  bit m_p21[2], m_pl[2];

  function automatic int pd_of(int k);
    return (k == 0) ? 6 : 4;
  endfunction

  function automatic int ns_of(int k);
    return (k == 0) ? 24 : 2;
  endfunction

  task automatic check(input string name, input int k, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
    end
  endtask

  always @(posedge MCLK) begin
    for (int k = 0; k < 2; k++) begin
      if (IC) begin
        m_t[k] = 0;
        m_r21[k] = 0; m_s21[k] = 0; m_p21[k] = 1'b0;
        m_rl[k] = 0;  m_sl[k] = 0;  m_pl[k] = 1'b0;
      end else begin
        if ((m_t[k] % (pd_of(k) * ns_of(k))) == pd_of(k) * ns_of(k) - 1) begin
          if (reg21_wr) begin m_r21[k] = int'(reg21_data); m_p21[k] = 1'b0; end
          else if (m_p21[k]) begin m_r21[k] = m_s21[k]; m_p21[k] = 1'b0; end
          if (lfo_wr) begin m_rl[k] = int'(lfo_data); m_pl[k] = 1'b0; end
          else if (m_pl[k]) begin m_rl[k] = m_sl[k]; m_pl[k] = 1'b0; end
        end else begin
          if (reg21_wr) begin m_s21[k] = int'(reg21_data); m_p21[k] = 1'b1; end
          if (lfo_wr) begin m_sl[k] = int'(lfo_data); m_pl[k] = 1'b1; end
        end
        m_t[k] = m_t[k] + 1;
      end
    end
  end

  always @(negedge MCLK) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        int pd, fr, ph, sl;
        pd = pd_of(k);
        fr = pd * ns_of(k);
        ph = m_t[k] % pd;
        sl = (m_t[k] / pd) % ns_of(k);
        check("c1", k, int'(o_c1[k]), int'(ph < 2));
        check("c2", k, int'(o_c2[k]), int'(ph == pd / 2 || ph == pd / 2 + 1));
        check("slot", k, int'(o_slot[k]), sl);
        check("fsm_sel23", k, int'(o_fsm[k]), int'(sl == ns_of(k) - 1));
        check("frame_start", k, int'(o_fs[k]), int'(m_t[k] >= fr && (m_t[k] % fr) == 0));
        check("ic_o", k, int'(o_ic[k]), int'(m_t[k] < fr));
        check("reg_21", k, int'(o_r21[k]), m_r21[k]);
        check("lfo", k, int'(o_lfo[k]), m_rl[k]);
        check("busy", k, int'(o_busy[k]), int'(m_p21[k] || m_pl[k]));
      end
    end
  end

  task automatic tick();
    @(posedge MCLK);
    #2;
  endtask

  // Advance until the 6x24 instance sits at frame position pos (slot*6+ph).
  task automatic wait_pos(input int pos);
    int n;
    n = 0;
    while ((m_t[0] % 144) != pos && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_pos: position %0d not reached within 200 cycles", pos);
    end
  endtask

  initial begin
    int n_ic0, n_ic1, n_fsm0, n_fsm1;

    IC = 1'b1;
    tick();
    chk_en = 1'b1;
    repeat (9) tick();
    check("rst_ic_o", 0, int'(o_ic[0]), 1);
    check("rst_c1", 0, int'(o_c1[0]), 1);
    check("rst_c2", 0, int'(o_c2[0]), 0);
    check("rst_reg21", 0, int'(o_r21[0]), 0);
    check("rst_busy", 0, int'(o_busy[0]), 0);
    check("rst_frame_start", 0, int'(o_fs[0]), 0);

    // Release: count clear-stretch and fsm_sel23 cycles over a fixed window.
    IC = 1'b0;
    n_ic0 = 0; n_ic1 = 0; n_fsm0 = 0; n_fsm1 = 0;
    for (int i = 0; i < 160; i++) begin
      n_ic0 += int'(o_ic[0]);
      n_ic1 += int'(o_ic[1]);
      n_fsm0 += int'(o_fsm[0]);
      n_fsm1 += int'(o_fsm[1]);
      if (i == 144) check("release_frame_start", 0, int'(o_fs[0]), 1);
      tick();
    end
    check("stretch_len", 0, n_ic0, 144);
    check("stretch_len", 1, n_ic1, 8);
    check("fsm_sel23_cycles", 0, n_fsm0, 6);
    check("fsm_sel23_cycles", 1, n_fsm1, 80);

    // Mid-frame write at slot 5.
    wait_pos(30);
    reg21_wr = 1'b1; reg21_data = 8'h02;
    tick();
    reg21_wr = 1'b0;
    check("midframe_busy", 0, int'(o_busy[0]), 1);
    wait_pos(143);
    check("midframe_hold", 0, int'(o_r21[0]), 8'h00);
    check("midframe_busy_wrap", 0, int'(o_busy[0]), 1);
    tick();
    check("midframe_commit", 0, int'(o_r21[0]), 8'h02);
    check("midframe_busy_clr", 0, int'(o_busy[0]), 0);

    // Last write wins.
    wait_pos(18);
    lfo_wr = 1'b1; lfo_data = 4'h9;
    tick();
    lfo_wr = 1'b0;
    wait_pos(60);
    lfo_wr = 1'b1; lfo_data = 4'hB;
    tick();
    lfo_wr = 1'b0;
    wait_pos(143);
    check("lww_hold", 0, int'(o_lfo[0]), 0);
    tick();
    check("lww_commit", 0, int'(o_lfo[0]), 4'hB);

    // Write exactly on the commit edge.
    wait_pos(143);
    lfo_wr = 1'b1; lfo_data = 4'hC;
    check("edge_busy_before", 0, int'(o_busy[0]), 0);
    tick();
    lfo_wr = 1'b0;
    check("edge_commit", 0, int'(o_lfo[0]), 4'hC);
    check("edge_busy_after", 0, int'(o_busy[0]), 0);

    // IC mid-frame with a write pending.
    wait_pos(30);
    reg21_wr = 1'b1; reg21_data = 8'hFF;
    tick();
    reg21_wr = 1'b0;
    wait_pos(72);
    IC = 1'b1;
    tick();
    check("ic_pending_reg21", 0, int'(o_r21[0]), 0);
    check("ic_pending_busy", 0, int'(o_busy[0]), 0);
    check("ic_pending_lfo", 0, int'(o_lfo[0]), 0);
    repeat (3) tick();
    IC = 1'b0;
    repeat (300) tick();
    check("ic_no_commit", 0, int'(o_r21[0]), 0);

    // Randomised traffic with occasional clears.
    for (int i = 0; i < 4000; i++) begin
      reg21_wr   = ($urandom_range(0, 15) == 0);
      reg21_data = 8'($urandom);
      lfo_wr     = ($urandom_range(0, 11) == 0);
      lfo_data   = 4'($urandom);
      IC         = ($urandom_range(0, 599) == 0);
      tick();
    end
    reg21_wr = 1'b0; lfo_wr = 1'b0; IC = 1'b0;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
